// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO register
// offsets, CTRL bit positions and small decode helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package dmem_responder_pkg;

   // Access size encodings; 2'b11 is decoded as a word access.
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // MMIO register byte offsets inside the 16-byte window.
   localparam logic [3:0] OFF_CTRL   = 4'h0;
   localparam logic [3:0] OFF_PRESET = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_LED    = 4'hC;

   // CTRL register bit indices.
   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   // CTRL register image; the packed order puts en at bit 0.
   typedef struct packed {
      logic irq_en;
      logic autoreload;
      logic en;
   } ctrl_t;

   // Natural alignment check for an access of the given size.
   function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] lo);
      case (sz)
         SZ_HALF: return (lo[0] == 1'b0);
         SZ_BYTE: return 1'b1;
         default: return (lo == 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_timer.sv
// Down-counting timer with sticky pending flag, driven by decoded MMIO strobes.
// Latency: register writes and count steps take effect on the next clk edge.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
// Ports: clk/rst, ctrl_we/preset_we/status_we strobes with shared wdata;
//        exports ctrl, preset, count_lo (COUNT[15:0]) and pending.
module dmem_timer
   import dmem_responder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_we,
   input  logic        preset_we,
   input  logic        status_we,
   input  logic [31:0] wdata,
   output ctrl_t       ctrl,
   output logic [31:0] preset,
   output logic [15:0] count_lo,
   output logic        pending
);

   logic [31:0] count;
   logic        expire;

   // Expiry is judged on the current state, so it still raises pending even
   // when a CTRL write in the same cycle overrides en and COUNT.
   assign expire   = ctrl.en && (count == 32'd0);
   assign count_lo = count[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         // Reloads below read the pre-write PRESET because of NBA ordering.
         if (preset_we)
            preset <= wdata;

         // Set beats write-1-to-clear.
         if (expire)
            pending <= 1'b1;
         else if (status_we && wdata[0])
            pending <= 1'b0;

         if (ctrl_we) begin
            ctrl <= ctrl_t'(wdata[2:0]);
            if (wdata[CTRL_EN])
               count <= preset;
         end else if (ctrl.en) begin
            if (count != 32'd0)
               count <= count - 32'd1;
            else if (ctrl.autoreload)
               count <= preset;
            else
               ctrl.en <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder for a single-cycle CPU: word RAM plus timer/LED MMIO window.
// Latency: loads are combinational in the same cycle; stores commit on the next clk edge.
// Backpressure: none; every access completes in one cycle.
// Ports: clk, rst (async, active-high); mem_w, Addr_in, Data_in, size, ld_unsigned
//        from the core; Data_out (combinational load data), irq, led.
// Optional: DMEM_MISALIGN_TRAP_EN adds a sticky misalign output that also forces irq.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int          RAM_AW    = 10,
   parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   output logic [31:0] Data_out,
   output logic        irq,
   output logic [15:0] led
`ifdef DMEM_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   localparam int DEPTH = 1 << RAM_AW;

   // ---------------- decode ----------------
   logic mmio_hit, ram_hit, aligned, is_word, mmio_ok, ram_ok, mmio_we;
   logic ctrl_we, preset_we, status_we, led_we;

   assign mmio_hit = (Addr_in[31:4] == MMIO_BASE[31:4]);
   assign ram_hit  = (Addr_in[31:RAM_AW+2] == '0) && !mmio_hit;
   assign aligned  = is_aligned(size, Addr_in[1:0]);
   assign is_word  = (size != SZ_HALF) && (size != SZ_BYTE);
   assign mmio_ok  = mmio_hit && is_word && aligned;
   assign ram_ok   = ram_hit && aligned;

   assign mmio_we   = mem_w && mmio_ok;
   assign ctrl_we   = mmio_we && (Addr_in[3:0] == OFF_CTRL);
   assign preset_we = mmio_we && (Addr_in[3:0] == OFF_PRESET);
   assign status_we = mmio_we && (Addr_in[3:0] == OFF_STATUS);
   assign led_we    = mmio_we && (Addr_in[3:0] == OFF_LED);

   // ---------------- timer ----------------
   ctrl_t       ctrl;
   logic [31:0] preset;
   logic [15:0] count_lo;
   logic        pending;

   dmem_timer u_timer (
      .clk       (clk),
      .rst       (rst),
      .ctrl_we   (ctrl_we),
      .preset_we (preset_we),
      .status_we (status_we),
      .wdata     (Data_in),
      .ctrl      (ctrl),
      .preset    (preset),
      .count_lo  (count_lo),
      .pending   (pending)
   );

   // ---------------- LED register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led <= '0;
      else if (led_we)
         led <= Data_in[15:0];
   end

   // ---------------- misalign trap ----------------
`ifdef DMEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         misalign <= 1'b0;
      else if ((mmio_hit || ram_hit) && !aligned)
         misalign <= 1'b1;
   end

   assign irq = (pending && ctrl.irq_en) || misalign;
`else
   assign irq = pending && ctrl.irq_en;
`endif

   // ---------------- RAM ----------------
   logic [31:0]       ram [DEPTH];
   logic [RAM_AW-1:0] widx;
   logic [3:0]        be;
   logic [31:0]       wlane;

   assign widx = Addr_in[RAM_AW+1:2];

   // Narrow stores are replicated across the word so the byte enables alone
   // pick the destination lane.
   always_comb begin
      be    = 4'hF;
      wlane = Data_in;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << Addr_in[1:0];
            wlane = {4{Data_in[7:0]}};
         end
         SZ_HALF: begin
            be    = Addr_in[1] ? 4'b1100 : 4'b0011;
            wlane = {2{Data_in[15:0]}};
         end
         default: ;
      endcase
   end

   // No reset: RAM contents survive rst.
   always_ff @(posedge clk) begin
      if (mem_w && ram_ok) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               ram[widx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   logic [31:0] rword, ram_rd, mmio_rd;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rword = ram[widx];
   assign rbyte = rword[{Addr_in[1:0], 3'b000} +: 8];
   assign rhalf = Addr_in[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      ram_rd = rword;
      case (size)
         SZ_BYTE: ram_rd = ld_unsigned ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
         SZ_HALF: ram_rd = ld_unsigned ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
         default: ;
      endcase
   end

   always_comb begin
      mmio_rd = '0;
      case (Addr_in[3:0])
         OFF_CTRL:   mmio_rd = {29'd0, ctrl};
         OFF_PRESET: mmio_rd = preset;
         OFF_STATUS: mmio_rd = {count_lo, 15'd0, pending};
         OFF_LED:    mmio_rd = {16'd0, led};
         default:    ;
      endcase
   end

   assign Data_out = ram_ok  ? ram_rd  :
                     mmio_ok ? mmio_rd : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, timer and reset
// sequences, then random traffic checked against a byte-level reference model.
// Latency: n/a. Backpressure: n/a.
module tb_dmem_responder;

   localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10;
   localparam logic [31:0] CTRL = 32'h7F00, PRE = 32'h7F04, STAT = 32'h7F08, LEDA = 32'h7F0C;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_w = 1'b0;
   logic [31:0] Addr_in = STAT;
   logic [31:0] Data_in = '0;
   logic [1:0]  size = W;
   logic        ld_unsigned = 1'b0;
   logic [31:0] Data_out;
   logic        irq;
   logic [15:0] led;
`ifdef DMEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   dmem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .mem_w       (mem_w),
      .Addr_in     (Addr_in),
      .Data_in     (Data_in),
      .size        (size),
      .ld_unsigned (ld_unsigned),
      .Data_out    (Data_out),
      .irq         (irq),
      .led         (led)
`ifdef DMEM_MISALIGN_TRAP_EN
      ,
      .misalign    (misalign)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   // ---------------- reference model ----------------
   bit [7:0]  mmem [4096];
   bit        m_en, m_ar, m_ie, m_pend, m_mis;
   bit [31:0] m_cnt, m_pre;
   bit [15:0] m_led;

   function automatic int nbytes(input logic [1:0] s);
      return (s == H) ? 2 : (s == B) ? 1 : 4;
   endfunction
   function automatic bit in_mmio(input logic [31:0] a);
      return (a >= 32'h7F00) && (a < 32'h7F10);
   endfunction
   function automatic bit in_ram(input logic [31:0] a);
      return a < 32'd4096;
   endfunction

   function automatic void m_reset();
      m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_mis = 0;
      m_cnt = 0; m_pre = 0; m_led = 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [1:0] s, input bit u);
      int n;
      logic [31:0] v;
      n = nbytes(s);
      v = 0;
      if (a % n != 0) return 0;
      if (in_mmio(a)) begin
         if (n != 4) return 0;
         case (a[3:0])
            4'h0: v = {29'd0, m_ie, m_ar, m_en};
            4'h4: v = m_pre;
            4'h8: v = {m_cnt[15:0], 15'd0, m_pend};
            default: v = {16'd0, m_led};
         endcase
         return v;
      end
      if (!in_ram(a)) return 0;
      for (int k = 0; k < n; k++) v = v | (32'(mmem[a + k]) << (8 * k));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic void m_step(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      int n;
      bit expire, mw;
      bit [31:0] old_pre;
      n = nbytes(s);
      expire = m_en && (m_cnt == 0);
      old_pre = m_pre;
      mw = w && in_mmio(a) && n == 4 && a % 4 == 0;
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((in_mmio(a) || in_ram(a)) && a % n != 0) m_mis = 1;
`endif
      if (mw && a[3:0] == 4'h8 && d[0]) m_pend = 0;
      if (expire) m_pend = 1;
      if (mw && a[3:0] == 4'h0) begin
         m_en = d[0]; m_ar = d[1]; m_ie = d[2];
         if (d[0]) m_cnt = old_pre;
      end else if (m_en) begin
         if (m_cnt != 0) m_cnt = m_cnt - 1;
         else if (m_ar) m_cnt = old_pre;
         else m_en = 0;
      end
      if (mw && a[3:0] == 4'h4) m_pre = d;
      if (mw && a[3:0] == 4'hC) m_led = d[15:0];
      if (w && in_ram(a) && a % n == 0)
         for (int k = 0; k < n; k++) mmem[a + k] = d[8*k +: 8];
   endfunction

   // ---------------- one bus cycle ----------------
   logic [31:0] got_rd, exp_rd;
   logic        got_irq, exp_irq;
   logic [15:0] got_led, exp_led;

   task automatic cycle(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input bit u);
      @(negedge clk);
      mem_w = w; Addr_in = a; Data_in = d; size = s; ld_unsigned = u;
      #1;
      got_rd = Data_out; got_irq = irq; got_led = led;
      exp_rd = m_read(a, s, u);
      exp_irq = (m_pend && m_ie) || m_mis;
      exp_led = m_led;
      @(posedge clk);
      m_step(w, a, d, s);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  s;
      bit          u;
      bit          c;
      logic [31:0] e;
   } vec_t;

   vec_t tv[23];

   initial begin
      tv[0]  = '{1, 32'h10,   32'h8899AABB, W, 0, 0, 32'h0};
      tv[1]  = '{0, 32'h11,   32'h0,        B, 0, 1, 32'hFFFFFFAA};
      tv[2]  = '{0, 32'h11,   32'h0,        B, 1, 1, 32'h000000AA};
      tv[3]  = '{0, 32'h12,   32'h0,        H, 0, 1, 32'hFFFF8899};
      tv[4]  = '{0, 32'h12,   32'h0,        H, 1, 1, 32'h00008899};
      tv[5]  = '{0, 32'h10,   32'h0,        W, 0, 1, 32'h8899AABB};
      tv[6]  = '{1, 32'h13,   32'hFFFFFF55, B, 0, 0, 32'h0};
      tv[7]  = '{0, 32'h10,   32'h0,        W, 0, 1, 32'h5599AABB};
      tv[8]  = '{1, 32'h10,   32'hABCD1234, H, 0, 0, 32'h0};
      tv[9]  = '{0, 32'h10,   32'h0,        W, 0, 1, 32'h55991234};
      tv[10] = '{0, 32'h10,   32'h0,        B, 0, 1, 32'h00000034};
      tv[11] = '{0, 32'h12,   32'h0,        W, 0, 1, 32'h0};
      tv[12] = '{1, 32'h12,   32'hDEADBEEF, W, 0, 0, 32'h0};
      tv[13] = '{0, 32'h10,   32'h0,        2'b11, 0, 1, 32'h55991234};
      tv[14] = '{0, 32'h11,   32'h0,        H, 1, 1, 32'h0};
      tv[15] = '{1, LEDA,     32'h12345678, W, 0, 0, 32'h0};
      tv[16] = '{0, LEDA,     32'h0,        W, 0, 1, 32'h00005678};
      tv[17] = '{1, LEDA,     32'hFFFFFFFF, B, 0, 0, 32'h0};
      tv[18] = '{0, LEDA,     32'h0,        B, 0, 1, 32'h0};
      tv[19] = '{0, LEDA,     32'h0,        W, 0, 1, 32'h00005678};
      tv[20] = '{1, 32'h1010, 32'hCAFEF00D, W, 0, 0, 32'h0};
      tv[21] = '{0, 32'h1010, 32'h0,        W, 0, 1, 32'h0};
      tv[22] = '{0, 32'h10,   32'h0,        W, 0, 1, 32'h55991234};

      m_reset();

      // reset state while rst is held
      #2;
      chk("rst_status", Data_out, 32'h0);
      chk("rst_irq", {31'd0, irq}, 32'h0);
      chk("rst_led", {16'd0, led}, 32'h0);
      Addr_in = CTRL;
      #1 chk("rst_ctrl", Data_out, 32'h0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 23; i++) begin
         cycle(tv[i].w, tv[i].a, tv[i].d, tv[i].s, tv[i].u);
         if (tv[i].c) chk($sformatf("vec%0d", i), got_rd, tv[i].e);
      end
      chk("led_out", {16'd0, got_led}, 32'h00005678);

`ifdef DMEM_MISALIGN_TRAP_EN
      cycle(0, 32'h10, 0, W, 0);
      chk("misalign_sticky", {31'd0, misalign}, 32'h1);
      chk("misalign_irq", {31'd0, got_irq}, 32'h1);
`endif
      // reset pulse between tests
      @(negedge clk);
      mem_w = 0; Addr_in = LEDA; size = W;
      rst = 1'b1;
      #1 chk("led_after_rst", Data_out, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("misalign_rst", {31'd0, misalign}, 32'h0);
`endif
      rst = 1'b0;
      m_reset();

      // one-shot timer
      cycle(1, PRE, 32'd3, W, 0);
      cycle(1, CTRL, 32'h5, W, 0);
      for (int k = 0; k < 4; k++) begin
         cycle(0, STAT, 0, W, 0);
         chk($sformatf("oneshot_cnt%0d", k), got_rd, {16'(3 - k), 16'h0});
         chk($sformatf("oneshot_irq%0d", k), {31'd0, got_irq}, 32'h0);
      end
      cycle(0, STAT, 0, W, 0);
      chk("oneshot_pend", got_rd, 32'h00000001);
      chk("oneshot_irq", {31'd0, got_irq}, 32'h1);
      cycle(0, CTRL, 0, W, 0);
      chk("oneshot_en_clr", got_rd, 32'h00000004);
      cycle(1, STAT, 32'h1, W, 0);
      cycle(0, STAT, 0, W, 0);
      chk("w1c_clear", got_rd, 32'h0);
      chk("w1c_irq", {31'd0, got_irq}, 32'h0);

      // autoreload, W1C races and CTRL write on expiry
      cycle(1, PRE, 32'd2, W, 0);
      cycle(1, CTRL, 32'h7, W, 0);
      cycle(0, STAT, 0, W, 0); chk("ar_c1", got_rd, 32'h00020000);
      cycle(0, STAT, 0, W, 0); chk("ar_c2", got_rd, 32'h00010000);
      cycle(0, STAT, 0, W, 0); chk("ar_c3", got_rd, 32'h00000000);
      cycle(1, STAT, 32'h1, W, 0); chk("ar_c4", got_rd, 32'h00020001);
      chk("ar_c4_irq", {31'd0, got_irq}, 32'h1);
      cycle(0, STAT, 0, W, 0); chk("ar_w1c_ok", got_rd, 32'h00010000);
      chk("ar_w1c_irq", {31'd0, got_irq}, 32'h0);
      cycle(1, STAT, 32'h1, W, 0);
      cycle(0, STAT, 0, W, 0); chk("ar_w1c_race", got_rd, 32'h00020001);
      chk("ar_race_irq", {31'd0, got_irq}, 32'h1);
      cycle(1, STAT, 32'h1, W, 0);
      cycle(1, CTRL, 32'h3, W, 0);
      cycle(0, STAT, 0, W, 0); chk("ctrl_on_expiry", got_rd, 32'h00020001);
      chk("ctrl_ie_off", {31'd0, got_irq}, 32'h0);
      cycle(1, CTRL, 32'h0, W, 0);
      cycle(1, STAT, 32'h1, W, 0);

      // asynchronous reset mid-count
      cycle(1, PRE, 32'd0, W, 0);
      cycle(1, CTRL, 32'h7, W, 0);
      cycle(1, LEDA, 32'h0000BEEF, W, 0);
      cycle(1, PRE, 32'd50, W, 0);
      cycle(0, STAT, 0, W, 0); chk("pre_rst_a", got_rd, 32'h00000001);
      cycle(0, STAT, 0, W, 0); chk("pre_rst_b", got_rd, 32'h00320001);
      chk("pre_rst_irq", {31'd0, got_irq}, 32'h1);
      chk("pre_rst_led", {16'd0, got_led}, 32'h0000BEEF);
      @(negedge clk);
      mem_w = 0; Addr_in = STAT; size = W;
      #1 chk("pre_rst_c", Data_out, 32'h00310001);
      #1 rst = 1'b1;
      #1;
      chk("arst_status", Data_out, 32'h0);
      chk("arst_irq", {31'd0, irq}, 32'h0);
      chk("arst_led", {16'd0, led}, 32'h0);
      Addr_in = CTRL;
      #1 chk("arst_ctrl", Data_out, 32'h0);
      rst = 1'b0;
      m_reset();
      cycle(0, 32'h10, 0, W, 0);
      chk("ram_kept", got_rd, 32'h55991234);

      // random traffic against the model
      for (int i = 0; i < 16; i++) cycle(1, 32'(4 * i), 32'h0, W, 0);
      for (int i = 0; i < 1500; i++) begin
         int r;
         logic [31:0] a, d;
         logic [1:0]  s;
         bit w;
         r = $urandom_range(0, 9);
         s = 2'($urandom_range(0, 3));
         w = ($urandom_range(0, 2) == 0);
         if (r < 7) a = $urandom_range(0, 63);
         else if (r < 9) a = 32'h7F00 + $urandom_range(0, 15);
         else a = 32'h1000 + $urandom_range(0, 63);
         if (in_mmio(a) && $urandom_range(0, 1) == 1) begin
            a[1:0] = 2'b00;
            s = W;
         end
         d = in_mmio(a) ? 32'($urandom_range(0, 15)) : $urandom;
         cycle(w, a, d, s, 1'($urandom_range(0, 1)));
         chk($sformatf("rnd%0d_rd", i), got_rd, exp_rd);
         chk($sformatf("rnd%0d_irq", i), {31'd0, got_irq}, {31'd0, exp_irq});
         chk($sformatf("rnd%0d_led", i), {16'd0, got_led}, {16'd0, exp_led});
`ifdef DMEM_MISALIGN_TRAP_EN
         #1 chk($sformatf("rnd%0d_mis", i), {31'd0, misalign}, {31'd0, m_mis});
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
